// File: rtl/circular_fifo_if.sv
// circular_fifo_if
// Bundles the FIFO's request/response signals so the FIFO and its user
// connect through a single port.
//   master : drives push, pop, data_in; observes data_out, status and flags
//   slave  : the FIFO itself; the mirror image of master
// Parameters WIDTH and CNTWID must match the FIFO instance they connect to.
interface circular_fifo_if #(
    parameter int WIDTH  = 8,
    parameter int CNTWID = 4
);
    logic              push;
    logic              pop;
    logic [WIDTH-1:0]  data_in;
    logic [WIDTH-1:0]  data_out;
    logic              empty;
    logic              full;
    logic [CNTWID-1:0] count;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, pop, data_in,
        input  data_out, empty, full, count, overflow, underflow
    );

    modport slave (
        input  push, pop, data_in,
        output data_out, empty, full, count, overflow, underflow
    );
endinterface

// File: rtl/circular_fifo.sv
// circular_fifo
// Synchronous first-word-fall-through FIFO built on a DEPTH x WIDTH register
// array with wrapping read/write pointers and an explicit occupancy counter.
// Ports:
//   clk      : single clock, all state updates on its rising edge
//   rst      : asynchronous active-high reset (clears pointers, count, flags)
//   fifo_bus : slave side of circular_fifo_if
//              push/pop/data_in in; data_out (= mem[rptr]), empty, full,
//              count, and the sticky overflow/underflow flags out
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module circular_fifo #(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 8,
    parameter int CNTWID = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    circular_fifo_if.slave  fifo_bus
);

    localparam int PTRW = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PTRW-1:0]   wptr_q, wptr_d;
    logic [PTRW-1:0]   rptr_q, rptr_d;
    logic [CNTWID-1:0] count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic empty;
    logic full;
    logic push_ok;
    logic pop_ok;

    // Status decode and acceptance. A push into a full FIFO is still taken
    // when a pop frees a slot in the same cycle; a pop on an empty FIFO is
    // never taken, even alongside a push (no bypass path).
    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CNTWID'(DEPTH));
        push_ok = fifo_bus.push && (!full || fifo_bus.pop);
        pop_ok  = fifo_bus.pop && !empty;
    end

    // Next-state logic. Pointers are exactly log2(DEPTH) bits wide, so the
    // increment wraps DEPTH-1 -> 0 on its own.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + 1'b1;
        end

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Flags are sticky: once set they only clear through reset.
        if (fifo_bus.push && !fifo_bus.pop && full) begin
            overflow_d = 1'b1;
        end
        if (fifo_bus.pop && !fifo_bus.push && empty) begin
            underflow_d = 1'b1;
        end
    end

    // Control state with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset. A write that slips in while rst is
    // high can only hit slot 0 with count held at 0, so it is never visible
    // and the first real push after reset overwrites it.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= fifo_bus.data_in;
        end
    end

    assign fifo_bus.data_out  = mem_q[rptr_q];
    assign fifo_bus.empty     = empty;
    assign fifo_bus.full      = full;
    assign fifo_bus.count     = count_q;
    assign fifo_bus.overflow  = overflow_q;
    assign fifo_bus.underflow = underflow_q;

endmodule

// File: tb/tb_circular_fifo.sv
// tb_circular_fifo
// Self-checking bench for circular_fifo (DEPTH=8, WIDTH=8). A scoreboard
// queue holds the words the FIFO should contain; accepted pushes append to
// it and accepted pops take from its front and compare against data_out.
module tb_circular_fifo;

    localparam int DEPTH  = 8;
    localparam int WIDTH  = 8;
    localparam int CNTWID = $clog2(DEPTH) + 1;

    logic clk;
    logic rst;

    circular_fifo_if #(.WIDTH(WIDTH), .CNTWID(CNTWID)) bus ();

    circular_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .CNTWID(CNTWID)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .fifo_bus(bus)
    );

    logic [WIDTH-1:0] sb_q[$];
    logic             exp_overflow;
    logic             exp_underflow;
    int               tests_run;
    int               tests_failed;

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guards against a stuck simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compares every registered output against the scoreboard state.
    task automatic checkState(input string tag);
        checkOutput({tag, "_count"}, 32'(bus.count), 32'(sb_q.size()));
        checkOutput({tag, "_empty"}, 32'(bus.empty), 32'(sb_q.size() == 0));
        checkOutput({tag, "_full"}, 32'(bus.full), 32'(sb_q.size() == DEPTH));
        checkOutput({tag, "_ovf"}, 32'(bus.overflow), 32'(exp_overflow));
        checkOutput({tag, "_unf"}, 32'(bus.underflow), 32'(exp_underflow));
        checkOutput({tag, "_excl"}, 32'(bus.empty && bus.full), 32'd0);
        if (sb_q.size() > 0) begin
            checkOutput({tag, "_head"}, 32'(bus.data_out), 32'(sb_q[0]));
        end
    endtask

    // One clock cycle of push/pop. Inputs change on the falling edge; the
    // fall-through word is checked mid-cycle, the new state after the edge.
    task automatic applyStimulus(input logic do_push, input logic do_pop,
                                 input logic [WIDTH-1:0] din, input string tag);
        logic push_ok;
        logic pop_ok;
        logic [WIDTH-1:0] popped;
        @(negedge clk);
        bus.push    = do_push;
        bus.pop     = do_pop;
        bus.data_in = din;
        #1;
        pop_ok  = do_pop && (sb_q.size() > 0);
        push_ok = do_push && ((sb_q.size() < DEPTH) || do_pop);
        if (do_push && !do_pop && sb_q.size() == DEPTH) exp_overflow = 1'b1;
        if (do_pop && !do_push && sb_q.size() == 0) exp_underflow = 1'b1;
        if (pop_ok) begin
            popped = sb_q.pop_front();
            checkOutput({tag, "_pop"}, 32'(bus.data_out), 32'(popped));
        end
        if (push_ok) sb_q.push_back(din);
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        checkState(tag);
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        exp_overflow  = 1'b0;
        exp_underflow = 1'b0;
        rst           = 1'b1;
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.data_in   = '0;

        #1;
        checkState("reset");
        @(negedge clk);
        rst = 1'b0;

        // Fill to full then drain in order.
        for (int k = 1; k <= DEPTH; k++) applyStimulus(1'b1, 1'b0, WIDTH'(k), "fill");
        for (int k = 0; k < DEPTH; k++) applyStimulus(1'b0, 1'b1, '0, "drain");

        // Refill, then a push while full must be dropped and flag overflow.
        for (int k = 1; k <= DEPTH; k++) applyStimulus(1'b1, 1'b0, WIDTH'(k), "refill");
        applyStimulus(1'b1, 1'b0, 8'hAA, "ovf");

        // Full push+pop: 0x01 leaves, 0x09 lands in the vacated slot.
        applyStimulus(1'b1, 1'b1, 8'h09, "fullpp");
        for (int k = 0; k < DEPTH; k++) applyStimulus(1'b0, 1'b1, '0, "drain2");

        // Underflow, then push+pop on empty: push only.
        applyStimulus(1'b0, 1'b1, '0, "unf");
        applyStimulus(1'b1, 1'b1, 8'h55, "emptypp");
        checkOutput("emptypp_data", 32'(bus.data_out), 32'h55);
        applyStimulus(1'b0, 1'b1, '0, "emptypp_pop");

        // Alternating push/pop across pointer wrap.
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) applyStimulus(1'b1, 1'b0, WIDTH'(8'h10 + k / 2), "wrap");
            else            applyStimulus(1'b0, 1'b1, '0, "wrap");
            checkOutput("wrap_cnt_le1", 32'(bus.count <= 1), 32'd1);
        end

        // Asynchronous reset between edges with five entries held.
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, WIDTH'(8'hC0 + k), "hold");
        @(negedge clk);
        #2;
        rst = 1'b1;
        sb_q.delete();
        exp_overflow  = 1'b0;
        exp_underflow = 1'b0;
        #1;
        checkState("async_rst");
        bus.push    = 1'b1;
        bus.data_in = 8'hEE;
        @(posedge clk);
        #1;
        checkState("rst_push_ign");
        @(negedge clk);
        bus.push = 1'b0;
        rst      = 1'b0;

        applyStimulus(1'b1, 1'b0, 8'h77, "post_rst");
        checkOutput("post_rst_data", 32'(bus.data_out), 32'h77);
        applyStimulus(1'b0, 1'b1, '0, "post_rst_pop");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
